// File: rtl/barcode_emitter.sv
// Bar/space frame serialiser: start guard, data MSB first, parity, stop guard.
// Define BARCODE_PARITY_EN to emit the even-parity symbol before the stop guard.
module barcode_emitter #(
  parameter int CODE_W        = 5,
  parameter int MODULE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [CODE_W-1:0] code,
  output logic              bar,
  output logic              busy,
  output logic              done
);

  localparam int PW = (MODULE_CYCLES > 1) ? $clog2(MODULE_CYCLES) : 1;
  localparam int IW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(MODULE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(CODE_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     pre, pre_n;
  logic [1:0]        phase, phase_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CODE_W-1:0] sreg, sreg_n;
  logic              par, par_n;
  logic              bar_n, busy_n, done_n;

  logic              mod_end;
  logic              guard;
  logic              sym_bit;
  logic [1:0]        last_ph;
  logic [1:0]        nph;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pre   <= '0;
      phase <= '0;
      idx   <= '0;
      sreg  <= '0;
      par   <= 1'b0;
      bar   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      phase <= phase_n;
      idx   <= idx_n;
      sreg  <= sreg_n;
      par   <= par_n;
      bar   <= bar_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Guards are "101"; data 0 is "10", data 1 is "110".
  // Every symbol starts with a bar module.
  always_comb begin
    state_n = state;
    pre_n   = pre;
    phase_n = phase;
    idx_n   = idx;
    sreg_n  = sreg;
    par_n   = par;
    bar_n   = bar;
    busy_n  = busy;
    done_n  = 1'b0;
    nph     = phase + 2'd1;
    mod_end = (pre == PRE_LAST);
    guard   = (state == START) || (state == STOP);
    sym_bit = (state == PAR) ? par : sreg[CODE_W-1];
    last_ph = (guard || sym_bit) ? 2'd2 : 2'd1;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n = START;
          pre_n   = '0;
          phase_n = '0;
          idx_n   = IDX_TOP;
          sreg_n  = code;
          par_n   = ^code;
          bar_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      default: begin
        if (!mod_end) begin
          pre_n = pre + PW'(1);
        end else if (phase != last_ph) begin
          pre_n   = '0;
          phase_n = nph;
          bar_n   = guard ? (nph != 2'd1) : (nph != last_ph);
        end else begin
          pre_n   = '0;
          phase_n = '0;
          bar_n   = 1'b1;
          unique case (state)
            START: state_n = DATA;
            DATA: begin
              sreg_n = sreg << 1;
              if (idx == '0) begin
`ifdef BARCODE_PARITY_EN
                state_n = PAR;
`else
                state_n = STOP;
`endif
              end else begin
                idx_n = idx - IW'(1);
              end
            end
            PAR:  state_n = STOP;
            STOP: begin
              state_n = IDLE;
              bar_n   = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_barcode_emitter.sv
// Bench for barcode_emitter: table of frames, scoreboard of bar modules,
// plus ignored-load, back-to-back and mid-frame reset sequences.
module tb_barcode_emitter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load1 = 1'b0;
  logic       load4 = 1'b0;
  logic [4:0] code1 = '0;
  logic [4:0] code4 = '0;
  logic       bar1, busy1, done1;
  logic       bar4, busy4, done4;

  int          checks = 0;
  int          errors = 0;
  bit          q[$];
  logic [31:0] cap;

  typedef struct {
    int         sel;
    logic [4:0] code;
    int         lp;
    int         ln;
  } vec_t;

  vec_t tbl[6];

  always #5 clock = ~clock;

  barcode_emitter #(.CODE_W(5), .MODULE_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .load(load1), .code(code1),
    .bar(bar1), .busy(busy1), .done(done1)
  );

  barcode_emitter #(.CODE_W(5), .MODULE_CYCLES(4)) u4 (
    .clock(clock), .reset(reset), .load(load4), .code(code4),
    .bar(bar4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_sym(input bit b, input int mc);
    repeat (mc) q.push_back(1'b1);
    if (b) repeat (mc) q.push_back(1'b1);
    repeat (mc) q.push_back(1'b0);
  endtask

  task automatic push_guard(input int mc);
    repeat (mc) q.push_back(1'b1);
    repeat (mc) q.push_back(1'b0);
    repeat (mc) q.push_back(1'b1);
  endtask

  task automatic push_frame(input logic [4:0] c, input int mc);
    push_guard(mc);
    for (int i = 4; i >= 0; i--) push_sym(c[i], mc);
`ifdef BARCODE_PARITY_EN
    push_sym(^c, mc);
`endif
    push_guard(mc);
  endtask

  task automatic drive(input int sel, input logic ld, input logic [4:0] c);
    if (sel != 0) begin
      load4 = ld;
      code4 = c;
    end else begin
      load1 = ld;
      code1 = c;
    end
  endtask

  // Called just after a negedge with the chosen DUT idle or in its done cycle.
  task automatic run(input int sel, input logic [4:0] c, input int inj,
                     input int len, input bit chain);
    int   mc;
    int   n;
    bit   ok;
    logic b, bs, dn, e;
    mc = (sel != 0) ? 4 : 1;
    n  = 0;
    ok = 1'b0;
    q.delete();
    push_frame(c, mc);
    cap = '0;
    drive(sel, 1'b1, c);
    @(negedge clock);
    for (int t = 0; t < 500; t++) begin
      drive(sel, (n == inj), 5'b00001);
      b  = (sel != 0) ? bar4 : bar1;
      bs = (sel != 0) ? busy4 : busy1;
      if (!bs) begin
        ok = 1'b1;
        break;
      end
      if (q.size() == 0) begin
        chk("overrun", 32'(b), 32'hx);
      end else begin
        e = q.pop_front();
        chk("bar", 32'(b), 32'(e));
      end
      cap = {cap[30:0], b};
      n++;
      @(negedge clock);
    end
    b  = (sel != 0) ? bar4 : bar1;
    dn = (sel != 0) ? done4 : done1;
    chk("timeout", 32'(ok), 32'd1);
    chk("done_pulse", 32'(dn), 32'd1);
    chk("idle_bar", 32'(b), 32'd0);
    chk("busy_len", 32'(n), 32'(len * mc));
    chk("leftover", 32'(q.size()), 32'd0);
    drive(sel, 1'b0, c);
    if (!chain) begin
      @(negedge clock);
      dn = (sel != 0) ? done4 : done1;
      bs = (sel != 0) ? busy4 : busy1;
      chk("done_once", 32'(dn), 32'd0);
      chk("idle_busy", 32'(bs), 32'd0);
    end
  endtask

  function automatic int flen(input vec_t v);
`ifdef BARCODE_PARITY_EN
    return v.lp;
`else
    return v.ln;
`endif
  endfunction

  initial begin
    logic [31:0] lit;
    vec_t        v;
`ifdef BARCODE_PARITY_EN
    lit = 32'b1011101011011010110101;
`else
    lit = 32'b1011101011011010101;
`endif
    tbl[0] = '{0, 5'b10110, 22, 19};
    tbl[1] = '{0, 5'b00000, 18, 16};
    tbl[2] = '{1, 5'b11111, 24, 21};
    tbl[3] = '{0, 5'b10101, 22, 19};
    tbl[4] = '{1, 5'b01100, 20, 18};
    tbl[5] = '{0, 5'b00001, 20, 17};

    repeat (3) begin
      @(negedge clock);
      chk("in_reset", 32'({bar1, busy1, done1, bar4, busy4, done4}), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset", 32'({bar1, busy1, done1, bar4, busy4, done4}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      run(v.sel, v.code, -1, flen(v), 1'b0);
      if (i == 0) chk("pattern_10110", cap, lit);
    end

    run(0, 5'b10110, 5, flen(tbl[0]), 1'b0);
    chk("ignored_load", cap, lit);
    run(1, 5'b11111, 5, flen(tbl[2]), 1'b0);

    run(0, 5'b10101, -1, flen(tbl[3]), 1'b1);
    run(0, 5'b00000, -1, flen(tbl[1]), 1'b0);
    run(1, 5'b01100, -1, flen(tbl[4]), 1'b1);
    run(1, 5'b00001, -1, flen(tbl[5]), 1'b0);

    drive(0, 1'b1, 5'b10110);
    @(negedge clock);
    drive(0, 1'b0, 5'b10110);
    repeat (6) @(negedge clock);
    chk("pre_abort_busy", 32'(busy1), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_bar", 32'(bar1), 32'd0);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    chk("abort_done_hold", 32'(done1), 32'd0);
    @(negedge clock);
    chk("abort_no_pulse", 32'({busy1, done1}), 32'd0);
    run(0, 5'b10110, -1, flen(tbl[0]), 1'b0);
    chk("pattern_after_abort", cap, lit);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
